// File: rtl/mips32_seq_shifter.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROTR), up to STEP positions per clock, one-cycle done pulse.
// Define SEQ_SHIFTER_ROTATE_EN to build the rotate path; otherwise op=11 behaves as SRL.
module mips32_seq_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 1
) (
  input  logic               clk1,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;
  localparam int         KW      = SHAMT_W + 1;
  localparam logic [KW-1:0] STEP_K = KW'(STEP);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     work_q, work_d;
  logic [SHAMT_W-1:0]   rem_q, rem_d;
  logic [1:0]           op_q, op_d;
  logic                 fill_q, fill_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [KW-1:0]        k;
  logic [WIDTH-1:0]     shifted;
  logic                 accept;

  // Per-cycle datapath: shift the working register by k = min(STEP, rem).
  always_comb begin
    k = ({1'b0, rem_q} < STEP_K) ? {1'b0, rem_q} : STEP_K;
    shifted = work_q;
    case (op_q)
      OP_SLL:  shifted = work_q << k;
      OP_SRA:  shifted = WIDTH'({{WIDTH{fill_q}}, work_q} >> k);
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROTR: shifted = WIDTH'({work_q, work_q} >> k);
`endif
      default: shifted = work_q >> k;
    endcase
  end

  always_comb begin
    accept   = start && (state_q != S_SHIFT);
    state_d  = state_q;
    work_d   = work_q;
    rem_d    = rem_q;
    op_d     = op_q;
    fill_d   = fill_q;
    result_d = result_q;
    case (state_q)
      S_SHIFT: begin
        work_d = shifted;
        rem_d  = rem_q - SHAMT_W'(k);
        if ({1'b0, rem_q} == k) begin
          state_d  = S_DONE;
          result_d = shifted;
        end
      end
      default: begin
        if (accept) begin
          work_d = operand;
          rem_d  = shamt;
          fill_d = operand[WIDTH-1];
`ifdef SEQ_SHIFTER_ROTATE_EN
          op_d   = op;
`else
          op_d   = (op == OP_ROTR) ? OP_SRL : op;
`endif
          if (shamt == '0) begin
            state_d  = S_DONE;
            result_d = operand;
          end else begin
            state_d  = S_SHIFT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      rem_q    <= '0;
      op_q     <= OP_SLL;
      fill_q   <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      fill_q   <= fill_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/mips32_seq_shifter.md
# mips32_seq_shifter

Multi-cycle sequential shift unit attached to the mips32 pipeline's EX stage, replacing software shift loops built from add/slt/branch sequences. Accepts an operand, shift amount and mode on a start pulse, shifts by up to STEP bit positions per clock, and returns the result with a one-cycle done pulse. Width, per-cycle step and mode set (including optional rotate) are parametrised.

## Interface
Parameters:
- WIDTH, 32: operand/result width in bits, ≥ 2.
- SHAMT_W, $clog2(WIDTH): shift-amount width.
- STEP, 1: maximum bit positions shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH.

Ports:
- clk1  input  1  single clock, rising edge; the codebase's phase-1 clock name.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only when the unit is accepting.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR.
- operand  input  WIDTH  value to shift.
- shamt  input  SHAMT_W  shift amount, 0 to WIDTH-1.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  shifted value; held until the next accepted start.

## Operation
- States: IDLE, SHIFT, DONE.
- Accepting means state IDLE or DONE. start=1 on an accepting edge latches operand, op and shamt into working registers, and sets rem=shamt.
  - rem=0 → DONE.
  - rem>0 → SHIFT.
- start in SHIFT is ignored. It is not queued, and latched inputs are unaffected.
- Each SHIFT edge:
  - k = min(STEP, rem).
  - Shift the working register by k positions.
  - rem -= k.
  - rem reaching 0 → DONE, and result is loaded from the final shifted value on the same edge.
- Mode fill rules:
  - SLL: zero fill from the LSB side.
  - SRL: zero fill from the MSB side.
  - SRA: fill with operand[WIDTH-1], captured at accept.
  - ROTR: bits leaving bit 0 re-enter at bit WIDTH-1.
- shamt=0: result = operand in every mode.
- DONE: done=1, busy=0.
  - Next edge with start=0 → IDLE.
  - Next edge with start=1 → back-to-back accept.
- result changes only on the edge that enters DONE. It is stable during IDLE and SHIFT.
- Inputs may change freely after the accepting edge.

## Timing
- Reset values: state IDLE, busy=0, done=0, result=0, rem=0, working register 0.
- Latency: count the accepting edge as edge 1, and let n = ceil(shamt/STEP).
  - done is high in the cycle after edge n+1.
  - shamt=0 → 1 edge.
  - WIDTH=32, STEP=1, shamt=31 → 32 edges.
- busy is high from after edge 1 until the edge entering DONE; it is never high together with done.
- done is exactly one cycle unless back-to-back starts create consecutive completions with shamt=0.
- Throughput: one operation per n+1 cycles. There is no idle bubble when start is held in DONE.
- Reset mid-operation: all state clears immediately (asynchronous). The in-flight operation is discarded, with no done pulse, and result is cleared to 0.
- Deassertion of rst is synchronised by the integrator. The first accept can occur on the first edge after release.

## Configuration
- SEQ_SHIFTER_ROTATE_EN defined: op=11 performs ROTR as above.
- Not defined: op=11 executes as SRL (zero fill), and the rotate datapath is not synthesised. Timing is identical in both builds.

## Test plan
- WIDTH=32, STEP=1: operand=29, op=SLL, shamt=3 → result=232, done after edge 4; busy high for exactly 3 cycles.
- WIDTH=32, STEP=1: operand=29, op=SRL, shamt=3 → result=3. Then operand=0xFFFFFFE3, op=SRA, shamt=3 → result=0xFFFFFFFC.
- WIDTH=32, STEP=4, SEQ_SHIFTER_ROTATE_EN: operand=0x0000001D, op=ROTR, shamt=4 → result=0xD0000001, done after edge 2.
  - Same stimulus without the macro → result=0x00000001.
- shamt=0 in each op with operand=0xA5A5A5A5 → result=0xA5A5A5A5, done after edge 1, busy never high.
- Start SLL shamt=5, then pulse start with different inputs during SHIFT → ignored. Result=operand<<5, single done pulse.
  - Start held high in DONE → next op accepted on that edge.
- Assert rst during SHIFT (shamt=20) → busy=0, done=0, result=0 asynchronously. No done pulse follows; the next accepted op completes normally.
